sram_like_arbiter: RTL and testbench

//  N-channel sram-like arbiter: merges NUM_CH sram-like masters (inst fetch, data, TLB refill, ...) onto one

---
 rtl/sram_like_arbiter_pkg.sv | 15 +
 rtl/sram_like_id_fifo.sv | 66 ++++++
 rtl/sram_like_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared types and helpers for the sram-like arbiter slice.
//   lock_state_e : request-lock FSM states (IDLE / HELD)
//   id_width()   : channel-ID width, never below 1 bit
package sram_like_arbiter_pkg;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_like_id_fifo.sv
// In-order ID FIFO: records which channel issued each accepted request so
// that responses can be routed back in order.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   push_i/id_i : enqueue the issuing channel ID
//   pop_i       : dequeue the head entry
//   head_o      : ID at the head (oldest outstanding request)
//   count_o     : number of stored entries (0..DEPTH)
//   full_o      : count_o == DEPTH
// The caller never pushes when full nor pops when empty.
module sram_like_id_fifo #(
  parameter  int unsigned ID_W  = 1,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [ID_W-1:0]  id_i,
  output logic [ID_W-1:0]  head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= id_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel sram-like arbiter: merges NUM_CH sram-like masters onto one
// sram-like slave port and routes in-order responses back to the issuer.
// Ports:
//   clk, resetn                 : clock, synchronous active-low reset
//   m_req/m_wr/m_size/m_wstrb/m_addr/m_wdata : per-channel request fields
//   m_addr_ok, m_data_ok        : one-hot per-channel handshakes
//   m_rdata                     : shared read data (valid with m_data_ok)
//   s_req..s_wdata              : slave request (granted channel's fields)
//   s_addr_ok, s_data_ok, s_rdata : slave handshakes / read data
//   outstanding                 : accepted, unanswered requests
//   err_spurious                : sticky, s_data_ok with nothing outstanding
// Configuration: define SRAM_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority, lowest channel index wins.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_CH-1:0]                m_req,
  input  logic [NUM_CH-1:0]                m_wr,
  input  logic [2*NUM_CH-1:0]              m_size,
  input  logic [NUM_CH*DATA_W/8-1:0]       m_wstrb,
  input  logic [NUM_CH*ADDR_W-1:0]         m_addr,
  input  logic [NUM_CH*DATA_W-1:0]         m_wdata,
  output logic [NUM_CH-1:0]                m_addr_ok,
  output logic [NUM_CH-1:0]                m_data_ok,
  output logic [DATA_W-1:0]                m_rdata,
  output logic                             s_req,
  output logic                             s_wr,
  output logic [1:0]                       s_size,
  output logic [DATA_W/8-1:0]              s_wstrb,
  output logic [ADDR_W-1:0]                s_addr,
  output logic [DATA_W-1:0]                s_wdata,
  input  logic                             s_addr_ok,
  input  logic                             s_data_ok,
  input  logic [DATA_W-1:0]                s_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             err_spurious
);

  localparam int unsigned ID_W  = id_width(NUM_CH);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned SW    = DATA_W / 8;

  lock_state_e      state_q, state_d;
  logic [ID_W-1:0]  lock_g_q, lock_g_d;
  logic [ID_W-1:0]  arb_g, g, head;
  logic             fifo_full, hs, pop;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count;
`ifdef SRAM_ARB_RR_EN
  logic [ID_W-1:0]  rr_q, rr_d;
`endif

  // Arbitration: first requesting channel starting from the search origin.
  always_comb begin
    logic        found;
    int unsigned idx;
    arb_g = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
`ifdef SRAM_ARB_RR_EN
      idx = (int unsigned'(rr_q) + off) % NUM_CH;
`else
      idx = off;
`endif
      if (!found && m_req[idx]) begin
        found = 1'b1;
        arb_g = ID_W'(idx);
      end
    end
  end

  // A stalled request keeps its grant so the slave sees stable fields.
  assign g     = (state_q == LOCK_HELD) ? lock_g_q : arb_g;
  assign s_req = resetn & (|m_req) & ~fifo_full;
  assign hs    = s_req & s_addr_ok;
  assign pop   = s_data_ok & (count != '0);

  always_comb begin
    s_wr    = 1'b0;
    s_size  = '0;
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (g == ID_W'(ch)) begin
        s_wr    = m_wr[ch];
        s_size  = m_size[ch*2 +: 2];
        s_wstrb = m_wstrb[ch*SW +: SW];
        s_addr  = m_addr[ch*ADDR_W +: ADDR_W];
        s_wdata = m_wdata[ch*DATA_W +: DATA_W];
      end
    end
  end

  assign m_addr_ok    = hs  ? (NUM_CH'(1) << g)    : '0;
  assign m_data_ok    = pop ? (NUM_CH'(1) << head) : '0;
  assign m_rdata      = s_rdata;
  assign outstanding  = count;
  assign err_spurious = err_q;

  always_comb begin
    state_d  = state_q;
    lock_g_d = lock_g_q;
    err_d    = err_q | (s_data_ok & (count == '0));
    case (state_q)
      LOCK_IDLE: begin
        if (s_req && !s_addr_ok) begin
          state_d  = LOCK_HELD;
          lock_g_d = g;
        end
      end
      LOCK_HELD: begin
        if (hs) state_d = LOCK_IDLE;
      end
      default: state_d = LOCK_IDLE;
    endcase
  end

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (hs) rr_d = (g == ID_W'(NUM_CH - 1)) ? '0 : g + ID_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= LOCK_IDLE;
      lock_g_q <= '0;
      err_q    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      rr_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lock_g_q <= lock_g_d;
      err_q    <= err_d;
`ifdef SRAM_ARB_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  sram_like_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (hs),
    .pop_i   (pop),
    .id_i    (g),
    .head_o  (head),
    .count_o (count),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  localparam int unsigned NCH  = 3;
  localparam int unsigned MAXO = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = DW / 8;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [NCH-1:0]        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [2*NCH-1:0]      m_size;
  logic [NCH*SW-1:0]     m_wstrb;
  logic [NCH*AW-1:0]     m_addr;
  logic [NCH*DW-1:0]     m_wdata;
  logic [DW-1:0]         m_rdata;
  logic                  s_req, s_wr, s_addr_ok, s_data_ok, err_spurious;
  logic [1:0]            s_size;
  logic [SW-1:0]         s_wstrb;
  logic [AW-1:0]         s_addr;
  logic [DW-1:0]         s_wdata, s_rdata;
  logic [$clog2(MAXO):0] outstanding;

  always #5 clk = ~clk;

  sram_like_arbiter #(
    .NUM_CH          (NCH),
    .MAX_OUTSTANDING (MAXO),
    .ADDR_W          (AW),
    .DATA_W          (DW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_size       (m_size),
    .m_wstrb      (m_wstrb),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_addr_ok    (m_addr_ok),
    .m_data_ok    (m_data_ok),
    .m_rdata      (m_rdata),
    .s_req        (s_req),
    .s_wr         (s_wr),
    .s_size       (s_size),
    .s_wstrb      (s_wstrb),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_addr_ok    (s_addr_ok),
    .s_data_ok    (s_data_ok),
    .s_rdata      (s_rdata),
    .outstanding  (outstanding),
    .err_spurious (err_spurious)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int unsigned   ch;
    logic [DW-1:0] data;
  } resp_t;

  resp_t       sb_q[$];     // expected responses, in slave return order
  int unsigned issue_q[$];  // issuers of accepted, unanswered requests
  bit          locked;
  int unsigned lock_ch;
  int unsigned rr;
  bit          err_m;

  // Master-side state: a channel holds its request until accepted.
  bit            pend   [NCH];
  logic          f_wr   [NCH];
  logic [1:0]    f_size [NCH];
  logic [SW-1:0] f_wstrb[NCH];
  logic [AW-1:0] f_addr [NCH];
  logic [DW-1:0] f_wdata[NCH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Winner: first pending channel at or after the search origin.
  function automatic int unsigned pick();
    int unsigned start;
`ifdef SRAM_ARB_RR_EN
    start = rr;
`else
    start = 0;
`endif
    for (int unsigned off = 0; off < NCH; off++) begin
      if (pend[(start + off) % NCH]) return (start + off) % NCH;
    end
    return 0;
  endfunction

  // Monitor: every response the DUT presents must match the scoreboard head.
  always @(negedge clk) begin
    resp_t r;
    if (m_data_ok !== '0) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp_unexpected: got m_data_ok=%b expected none", m_data_ok);
      end else begin
        r = sb_q.pop_front();
        chk("resp_ch", 64'(m_data_ok), 64'(1) << r.ch);
        chk("resp_rdata", 64'(m_rdata), 64'(r.data));
      end
    end
  end

  task automatic cycle(input bit rst, input int unsigned p_new,
                       input int unsigned p_aok, input int unsigned p_dok);
    bit            full, e_sreq, hs, pop;
    int unsigned   g;
    logic [NCH-1:0] e_aok, e_dok;
    int unsigned   e_out;
    bit            e_err;

    @(posedge clk);
    #1;
    resetn = !rst;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      if (!pend[ch] && ($urandom_range(99) < p_new)) begin
        pend[ch]     = 1'b1;
        f_wr[ch]     = 1'($urandom);
        f_size[ch]   = 2'($urandom);
        f_wstrb[ch]  = SW'($urandom);
        f_addr[ch]   = $urandom;
        f_wdata[ch]  = $urandom;
      end
      m_req[ch]                = pend[ch];
      m_wr[ch]                 = f_wr[ch];
      m_size[ch*2 +: 2]        = f_size[ch];
      m_wstrb[ch*SW +: SW]     = f_wstrb[ch];
      m_addr[ch*AW +: AW]      = f_addr[ch];
      m_wdata[ch*DW +: DW]     = f_wdata[ch];
    end
    s_addr_ok = !rst && ($urandom_range(99) < p_aok);
    s_data_ok = !rst && ($urandom_range(99) < p_dok);
    s_rdata   = $urandom;

    // Expected outputs from the pre-edge model state.
    full   = (issue_q.size() == MAXO);
    e_sreq = !rst && (m_req != '0) && !full;
    g      = locked ? lock_ch : pick();
    hs     = e_sreq && s_addr_ok;
    e_aok  = '0;
    if (hs) e_aok[g] = 1'b1;
    pop    = s_data_ok && (issue_q.size() != 0);
    e_dok  = '0;
    if (pop) e_dok[issue_q[0]] = 1'b1;
    e_out  = issue_q.size();
    e_err  = err_m;

    // Advance the model across the coming edge.
    if (rst) begin
      issue_q.delete();
      locked = 1'b0;
      rr     = 0;
      err_m  = 1'b0;
    end else begin
      if (pop) sb_q.push_back('{ch: issue_q.pop_front(), data: s_rdata});
      if (s_data_ok && !pop) err_m = 1'b1;
      if (hs) begin
        issue_q.push_back(g);
        pend[g] = 1'b0;
        rr      = (g + 1) % NCH;
        locked  = 1'b0;
      end else if (e_sreq) begin
        locked  = 1'b1;
        lock_ch = g;
      end
    end

    @(negedge clk);
    chk("s_req", 64'(s_req), 64'(e_sreq));
    chk("m_addr_ok", 64'(m_addr_ok), 64'(e_aok));
    chk("m_data_ok", 64'(m_data_ok), 64'(e_dok));
    chk("outstanding", 64'(outstanding), 64'(e_out));
    chk("err_spurious", 64'(err_spurious), 64'(e_err));
    if (e_sreq) begin
      chk("s_addr", 64'(s_addr), 64'(f_addr[g]));
      chk("s_wr", 64'(s_wr), 64'(f_wr[g]));
      chk("s_size", 64'(s_size), 64'(f_size[g]));
      chk("s_wstrb", 64'(s_wstrb), 64'(f_wstrb[g]));
      chk("s_wdata", 64'(s_wdata), 64'(f_wdata[g]));
    end
  endtask

  initial begin
    resetn    = 1'b0;
    m_req     = '0;
    m_wr      = '0;
    m_size    = '0;
    m_wstrb   = '0;
    m_addr    = '0;
    m_wdata   = '0;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    s_rdata   = '0;
    locked    = 1'b0;
    lock_ch   = 0;
    rr        = 0;
    err_m     = 1'b0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      pend[ch]    = 1'b0;
      f_wr[ch]    = 1'b0;
      f_size[ch]  = '0;
      f_wstrb[ch] = '0;
      f_addr[ch]  = '0;
      f_wdata[ch] = '0;
    end

    // Reset with every channel requesting: slave request must stay low.
    repeat (2) cycle(1, 100, 0, 0);
    // Mixed traffic, clean responses first (no spurious yet).
    repeat (300) cycle(0, 40, 50, 0);
    repeat (400) cycle(0, 40, 50, 30);
    // Heavy requests, rare responses: fill to MAX_OUTSTANDING.
    repeat (400) cycle(0, 80, 70, 10);
    // Slave stalls addr_ok often: long locks, arrivals during lock.
    repeat (300) cycle(0, 50, 15, 40);
    // Mid-run reset clears sticky error and outstanding state.
    repeat (2) cycle(1, 60, 0, 0);
    repeat (400) cycle(0, 60, 60, 50);
    // Drain everything.
    repeat (60) cycle(0, 0, 100, 100);

    @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
